// File: rtl/change_dispenser.sv
// Pays out change one coin at a time (largest denomination first) and tracks the tube stock.
// 1 cycle from start to coin selection, then 2+ cycles per coin; holds EJECT until coin_ack.
module change_dispenser #(
    parameter int INIT_STOCK = 10,
    parameter int STOCK_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        change_amount,
    output logic [1:0]         coin_out,
    output logic               coin_valid,
    input  logic               coin_ack,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        remaining,
    input  logic               refill,
    input  logic [1:0]         refill_coin,
    output logic [STOCK_W-1:0] stock_500,
    output logic [STOCK_W-1:0] stock_1000,
    output logic [STOCK_W-1:0] stock_2000,
    output logic [STOCK_W-1:0] stock_5000
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [STOCK_W-1:0] STOCK_MAX  = {STOCK_W{1'b1}};
    localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);

    function automatic logic [15:0] coin_value(input logic [1:0] c);
        case (c)
            2'd0:    return 16'd500;
            2'd1:    return 16'd1000;
            2'd2:    return 16'd2000;
            default: return 16'd5000;
        endcase
    endfunction

    state_t             r_state;
    logic [1:0]         r_coin;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [15:0]        r_rem;
    logic [STOCK_W-1:0] r_stock [4];

    logic               w_take;
    logic               w_found;
    logic [1:0]         w_sel;
    logic [3:0]         w_inc;
    logic [3:0]         w_dec;

    assign w_take = (r_state == S_EJECT) && coin_ack;

    // Ascending scan: the last eligible denomination wins, i.e. the largest one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_rem >= coin_value(2'(i)) && r_stock[i] != '0) begin
                w_found = 1'b1;
                w_sel   = 2'(i);
            end
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < 4; i++) begin
            w_inc[i] = refill && (refill_coin == 2'(i));
            w_dec[i] = w_take && (r_coin == 2'(i));
        end
    end

    // A refill and a payout of the same coin in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) r_stock[i] <= STOCK_INIT;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_inc[i] && !w_dec[i] && r_stock[i] != STOCK_MAX)
                    r_stock[i] <= r_stock[i] + 1'b1;
                else if (w_dec[i] && !w_inc[i])
                    r_stock[i] <= r_stock[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_coin  <= 2'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_rem   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem   <= change_amount;
                        r_busy  <= 1'b1;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_rem == 16'd0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_found) begin
                        r_coin  <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= S_EJECT;
                    end else begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FAIL;
                    end
                end
                S_EJECT: begin
                    if (coin_ack) begin
                        r_valid <= 1'b0;
                        r_rem   <= r_rem - coin_value(r_coin);
                        r_state <= S_SELECT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign coin_out   = r_coin;
    assign coin_valid = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign remaining  = r_rem;
    assign stock_500  = r_stock[0];
    assign stock_1000 = r_stock[1];
    assign stock_2000 = r_stock[2];
    assign stock_5000 = r_stock[3];

endmodule
